// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
//   RATE_W        : width of the clocks-per-bit value
//   uart_state_t  : frame state encoding (IDLE/START/DATA/PARITY/STOP)
//   parity_bit()  : parity bit for a data word (odd = 1 selects odd parity)
package uart_pkg;
  localparam int RATE_W = 19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  function automatic logic parity_bit(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART receiver.
//   start : restart the count; latches rate for the rest of the frame
//   half  : with start, the first period is rate>>1 (start-bit centre)
//   rate  : clocks per bit time
//   tick  : one-cycle strobe at the end of each period; after a tick the
//           timer reloads with the full latched rate
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              start,
  input  logic              half,
  input  logic [RATE_W-1:0] rate,
  output logic              tick
);
  localparam logic [RATE_W-1:0] ONE = RATE_W'(1);

  logic [RATE_W-1:0] cnt, tgt, rate_q;
  logic              run;

  // Full-width compare, no wrap; tgt is always >= 1 for supported rates.
  assign tick = run && (cnt == tgt - ONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      tgt    <= '0;
      rate_q <= '0;
      run    <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      tgt    <= half ? (rate >> 1) : rate;
      rate_q <= rate;
      run    <= 1'b1;
    end else if (tick) begin
      cnt <= '0;
      tgt <= rate_q;
    end else if (run) begin
      cnt <= cnt + ONE;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 7/8 data bits, optional odd/even parity, one stop bit.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_rx           : serial line (idle high), synchronized internally
//   i_read         : host acknowledge pulse, clears ready and error flags
//   i_eight/i_pen/i_ohel/i_rate : frame format, latched at start edge
//   o_byte         : last received data (bit 7 = 0 in 7-bit mode)
//   o_rxrdy        : unread byte held
//   o_perr/o_ferr/o_ovf : parity, framing, overrun flags
module uart_rx
  import uart_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx,
  input  logic              i_read,
  input  logic              i_eight,
  input  logic              i_pen,
  input  logic              i_ohel,
  input  logic [RATE_W-1:0] i_rate,
  output logic [7:0]        o_byte,
  output logic              o_rxrdy,
  output logic              o_perr,
  output logic              o_ferr,
  output logic              o_ovf
);
  uart_state_t state, state_n;

  logic       rx_s1, rx_s2, rx_d;
  logic       fall, tick, last_bit;
  logic       tmr_start, tmr_half, frame_done;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, data_w;
  logic       eight_q, pen_q, ohel_q, perr_p;

  // rx_d is the previous synchronized sample, used only for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= i_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign fall     = rx_d & ~rx_s2;
  assign last_bit = (bit_cnt == (eight_q ? 3'd7 : 3'd6));
  // In 7-bit mode only seven shifts happen, so data sits in shreg[7:1].
  assign data_w   = eight_q ? shreg : {1'b0, shreg[7:1]};

  uart_bit_timer u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .start   (tmr_start),
    .half    (tmr_half),
    .rate    (i_rate),
    .tick    (tick)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n    = state;
    tmr_start  = 1'b0;
    tmr_half   = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE:   if (fall) begin
                   state_n   = ST_START;
                   tmr_start = 1'b1;
                   tmr_half  = 1'b1;
                 end
      ST_START:  if (tick) state_n = rx_s2 ? ST_IDLE : ST_DATA;
      ST_DATA:   if (tick && last_bit) state_n = pen_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_n = ST_STOP;
      ST_STOP:   if (tick) begin
                   state_n    = ST_IDLE;
                   frame_done = 1'b1;
                 end
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      ohel_q  <= 1'b0;
      perr_p  <= 1'b0;
      o_byte  <= '0;
      o_rxrdy <= 1'b0;
      o_perr  <= 1'b0;
      o_ferr  <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      if (state == ST_IDLE && fall) begin
        eight_q <= i_eight;
        pen_q   <= i_pen;
        ohel_q  <= i_ohel;
        perr_p  <= 1'b0;
      end
      if (state == ST_START && tick) bit_cnt <= '0;
      if (state == ST_DATA && tick) begin
        shreg   <= {rx_s2, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == ST_PARITY && tick)
        perr_p <= (rx_s2 != parity_bit(data_w, ohel_q));
      // Completion takes priority over a coincident read; overrun only
      // counts if the previous byte is still unread after this cycle.
      if (frame_done) begin
        o_byte  <= data_w;
        o_rxrdy <= 1'b1;
        o_perr  <= perr_p;
        o_ferr  <= ~rx_s2;
        o_ovf   <= o_rxrdy & ~i_read;
      end else if (i_read) begin
        o_rxrdy <= 1'b0;
        o_perr  <= 1'b0;
        o_ferr  <= 1'b0;
        o_ovf   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  logic        clk = 1'b0;
  logic        rst_n, rx, read, eight, pen, ohel;
  logic [18:0] rate;
  logic [7:0]  o_byte;
  logic        o_rxrdy, o_perr, o_ferr, o_ovf;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uart_rx dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_rx    (rx),
    .i_read  (read),
    .i_eight (eight),
    .i_pen   (pen),
    .i_ohel  (ohel),
    .i_rate  (rate),
    .o_byte  (o_byte),
    .o_rxrdy (o_rxrdy),
    .o_perr  (o_perr),
    .o_ferr  (o_ferr),
    .o_ovf   (o_ovf)
  );

  typedef struct {
    int         r;
    logic [7:0] data;
    logic       e8, pe, odd, pb, sb;
    logic [7:0] xbyte;
    logic       xperr, xferr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic v, input int r);
    rx = v;
    repeat (r) @(posedge clk);
    #1;
  endtask

  // Start bit, data LSB first, optional parity, one stop bit, back to idle.
  task automatic send_frame(input logic [7:0] d, input logic e8, input logic pe,
                            input logic pb, input logic sb, input int r);
    @(posedge clk);
    #1;
    bit_out(1'b0, r);
    for (int i = 0; i < (e8 ? 8 : 7); i++) bit_out(d[i], r);
    if (pe) bit_out(pb, r);
    bit_out(sb, r);
    rx = 1'b1;
  endtask

  task automatic pulse_read();
    @(posedge clk);
    #1 read = 1'b1;
    @(posedge clk);
    #1 read = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rate data   e8 pe odd pb  sb  xbyte xperr xferr
    vecs[0] = '{109, 8'h3A, 0, 0, 0, 0, 1, 8'h3A, 0, 0};
    vecs[1] = '{109, 8'hA5, 1, 1, 0, 1, 1, 8'hA5, 1, 0}; // even parity should be 0
    vecs[2] = '{109, 8'hC3, 1, 1, 1, 1, 1, 8'hC3, 0, 0}; // odd parity ok
    vecs[3] = '{109, 8'h5A, 1, 0, 0, 0, 0, 8'h5A, 0, 1}; // stop bit low
    vecs[4] = '{16,  8'hFF, 0, 1, 0, 1, 1, 8'h7F, 0, 0}; // 7 bits, even ok
    vecs[5] = '{16,  8'h81, 1, 1, 1, 0, 0, 8'h81, 1, 1}; // bad parity + stop
    vecs[6] = '{8,   8'h6B, 1, 0, 0, 0, 1, 8'h6B, 0, 0};

    rst_n = 1'b0; rx = 1'b1; read = 1'b0;
    eight = 1'b0; pen = 1'b0; ohel = 1'b0; rate = 19'd109;
    #23;
    chk("reset byte", o_byte, 8'h00);
    chk("reset rxrdy", o_rxrdy, 0);
    chk("reset perr", o_perr, 0);
    chk("reset ferr", o_ferr, 0);
    chk("reset ovf", o_ovf, 0);
    rst_n = 1'b1;
    idle(5);

    foreach (vecs[i]) begin
      eight = vecs[i].e8; pen = vecs[i].pe; ohel = vecs[i].odd;
      rate  = 19'(vecs[i].r);
      send_frame(vecs[i].data, vecs[i].e8, vecs[i].pe, vecs[i].pb, vecs[i].sb, vecs[i].r);
      idle(10);
      chk($sformatf("v%0d byte", i), o_byte, vecs[i].xbyte);
      chk($sformatf("v%0d rxrdy", i), o_rxrdy, 1);
      chk($sformatf("v%0d perr", i), o_perr, vecs[i].xperr);
      chk($sformatf("v%0d ferr", i), o_ferr, vecs[i].xferr);
      chk($sformatf("v%0d ovf", i), o_ovf, 0);
      pulse_read();
      idle(2);
      chk($sformatf("v%0d rd rxrdy", i), o_rxrdy, 0);
      chk($sformatf("v%0d rd perr", i), o_perr, 0);
      chk($sformatf("v%0d rd ferr", i), o_ferr, 0);
      chk($sformatf("v%0d rd byte hold", i), o_byte, vecs[i].xbyte);
    end

    // 20-clock glitch: false start, then a real frame still works.
    eight = 1'b1; pen = 1'b0; ohel = 1'b0; rate = 19'd109;
    @(posedge clk);
    #1 rx = 1'b0;
    idle(20);
    rx = 1'b1;
    idle(300);
    chk("glitch rxrdy", o_rxrdy, 0);
    chk("glitch perr", o_perr, 0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 109);
    idle(10);
    chk("post glitch byte", o_byte, 8'h3C);
    chk("post glitch rxrdy", o_rxrdy, 1);
    pulse_read();

    // Overrun: two frames without read.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 109);
    idle(10);
    chk("ovr first ovf", o_ovf, 0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 109);
    idle(10);
    chk("ovr byte", o_byte, 8'h22);
    chk("ovr ovf", o_ovf, 1);
    chk("ovr rxrdy", o_rxrdy, 1);

    // Read in the completion cycle: stop sample lands 1038 clocks after
    // the edge that drives the start bit (3 sync + 54 half + 9*109).
    fork
      send_frame(8'h44, 1'b1, 1'b0, 1'b0, 1'b1, 109);
      begin
        @(posedge clk);
        repeat (1037) @(posedge clk);
        #1 read = 1'b1;
        @(posedge clk);
        #1 read = 1'b0;
      end
    join
    idle(10);
    chk("rd+done byte", o_byte, 8'h44);
    chk("rd+done rxrdy", o_rxrdy, 1);
    chk("rd+done ovf", o_ovf, 0);

    // Reset during DATA (line high there), partial frame discarded.
    fork
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 109);
      begin
        @(posedge clk);
        repeat (500) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst rxrdy", o_rxrdy, 0);
        chk("midrst byte", o_byte, 8'h00);
        chk("midrst ovf", o_ovf, 0);
        #1 rst_n = 1'b1;
      end
    join
    idle(200);
    chk("after rst rxrdy", o_rxrdy, 0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 109);
    idle(10);
    chk("after rst byte", o_byte, 8'h55);
    chk("after rst rxrdy2", o_rxrdy, 1);
    chk("after rst perr", o_perr, 0);
    chk("after rst ferr", o_ferr, 0);
    chk("after rst ovf", o_ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
